cpu: RTL and testbench

Single-cycle 8-bit processor core for the CO224 simple ISA with flow control (j, beq). Contains the program counter, an 8×8-bit register file, control decode, an 8-bit ALU and branch/jump target logic. Instruction memory is external: the core drives a byte address on PC and receives a 32-bit instruction combinationally.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/cpu_alu.sv | 30 +++
 rtl/cpu_reg_file.sv | 34 +++
 rtl/cpu.sv | 71 +++++++
 tb/tb_cpu.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit single-cycle core.
//   - datapath / register-index widths
//   - opcode constants and ALU operation encodings
//   - ctrl_t control word and its opcode decoder
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_W    = 3;
  localparam int NUM_REGS = 1 << REG_W;
  localparam int PC_W     = 32;

  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_SUB   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_J     = 8'h04;
  localparam logic [7:0] OP_BEQ   = 8'h05;
  localparam logic [7:0] OP_MOV   = 8'h06;
  localparam logic [7:0] OP_LOADI = 8'h07;

  localparam logic [2:0] ALUOP_FWD = 3'b000;
  localparam logic [2:0] ALUOP_ADD = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;

  // Control word produced from the opcode alone.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       imm_sel;   // operand 2 from the immediate byte instead of RS
    logic       neg_sel;   // two's-complement operand 2 (sub / beq compare)
    logic       wr_en;     // register file write
    logic       jump;      // unconditional PC-relative jump
    logic       branch;    // PC-relative jump when the ALU result is zero
  } ctrl_t;

  // Unlisted opcodes fall through to the all-zero word: no write, PC+4.
  function automatic ctrl_t decode_op(input logic [7:0] op);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_FWD;
    case (op)
      OP_ADD:   begin c.alu_op = ALUOP_ADD; c.wr_en = 1'b1; end
      OP_SUB:   begin c.alu_op = ALUOP_ADD; c.neg_sel = 1'b1; c.wr_en = 1'b1; end
      OP_AND:   begin c.alu_op = ALUOP_AND; c.wr_en = 1'b1; end
      OP_OR:    begin c.alu_op = ALUOP_OR;  c.wr_en = 1'b1; end
      OP_J:     begin c.jump = 1'b1; end
      OP_BEQ:   begin c.alu_op = ALUOP_ADD; c.neg_sel = 1'b1; c.branch = 1'b1; end
      OP_MOV:   begin c.alu_op = ALUOP_FWD; c.wr_en = 1'b1; end
      OP_LOADI: begin c.alu_op = ALUOP_FWD; c.imm_sel = 1'b1; c.wr_en = 1'b1; end
      default:  c = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: 8-bit combinational ALU, carry discarded.
//   data1  in  8  first operand (RT)
//   data2  in  8  second operand (RS / immediate, possibly negated)
//   alu_op in  3  ALUOP_* select
//   result out 8  operation result
//   zero   out 1  result == 0
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [2:0]        alu_op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALUOP_FWD: result = data2;
      ALUOP_ADD: result = data1 + data2;
      ALUOP_AND: result = data1 & data2;
      ALUOP_OR:  result = data1 | data2;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_reg_file.sv
// cpu_reg_file: 8 x 8-bit register file.
//   clk      in  1  write clock (rising edge)
//   rst_n    in  1  async active-low clear of all registers
//   wr_en    in  1  write enable
//   wr_addr  in  3  write index
//   wr_data  in  8  write data
//   rd_addr1 in  3  read port 1 index, rd_data1 out 8
//   rd_addr2 in  3  read port 2 index, rd_data2 out 8
module cpu_reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_W-1:0]  rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [REG_W-1:0]  rd_addr2,
  output logic [DATA_W-1:0] rd_data2
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // Clear wins over a write, so an instruction caught by reset never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     regs <= '0;
    else if (wr_en) regs[wr_addr] <= wr_data;
  end

  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

endmodule

// File: rtl/cpu.sv
// cpu: single-cycle 8-bit core (add/sub/and/or/j/beq/mov/loadi).
//   CLK         in  1   system clock, state updates on rising edge
//   RESET       in  1   async active-low; clears PC and registers
//   PC          out 32  byte address of current instruction (word aligned)
//   INSTRUCTION in  32  instruction at PC from external memory
// Fields: [31:24] opcode, [23:16] rd / signed word offset,
//         [15:8] RT, [7:0] RS / immediate.
module cpu
  import cpu_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  output logic [PC_W-1:0] PC,
  input  logic [31:0]     INSTRUCTION
);

  ctrl_t             ctrl;
  logic [REG_W-1:0]  rd_addr, rt_addr, rs_addr;
  logic [DATA_W-1:0] rt_data, rs_data;
  logic [DATA_W-1:0] op2_raw, op2;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic [PC_W-1:0]   pc_plus4, br_off, br_target, next_pc;
  logic              take;
  logic              unused_bits;

  assign ctrl    = decode_op(INSTRUCTION[31:24]);
  assign rd_addr = INSTRUCTION[16 +: REG_W];
  assign rt_addr = INSTRUCTION[8 +: REG_W];
  assign rs_addr = INSTRUCTION[0 +: REG_W];

  // Upper bits of the RT byte carry no meaning in this ISA.
  assign unused_bits = &{1'b0, INSTRUCTION[15:11]};

  cpu_reg_file u_rf (
    .clk      (CLK),
    .rst_n    (RESET),
    .wr_en    (ctrl.wr_en),
    .wr_addr  (rd_addr),
    .wr_data  (alu_res),
    .rd_addr1 (rt_addr),
    .rd_data1 (rt_data),
    .rd_addr2 (rs_addr),
    .rd_data2 (rs_data)
  );

  // Subtraction and the beq compare reuse the adder with a negated operand 2.
  assign op2_raw = ctrl.imm_sel ? INSTRUCTION[7:0] : rs_data;
  assign op2     = ctrl.neg_sel ? (~op2_raw + 8'd1) : op2_raw;

  cpu_alu u_alu (
    .data1  (rt_data),
    .data2  (op2),
    .alu_op (ctrl.alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Offset is a signed word count relative to PC+4; the sum wraps at 2^32.
  assign pc_plus4  = PC + 32'd4;
  assign br_off    = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
  assign br_target = pc_plus4 + br_off;
  assign take      = ctrl.jump | (ctrl.branch & alu_zero);
  assign next_pc   = take ? br_target : pc_plus4;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) PC <= '0;
    else        PC <= next_pc;
  end

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic [31:0] imem [64];

  int checks = 0;
  int errors = 0;

  // Reference state: architectural PC and registers.
  logic [31:0] mpc;
  logic [7:0]  mreg [8];

  localparam logic [31:0] NOP = 32'hFF00_0000;

  assign INSTRUCTION = imem[PC[7:2]];

  cpu dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION)
  );

  always #4 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    int          rd;
    logic [7:0]  val;
  } vec_t;

  vec_t vt [13];

  function automatic logic [31:0] enc(input int op, input int d, input int t, input int s);
    return {8'(op), 8'(d), 8'(t), 8'(s)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"}, PC, mpc);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_r%0d", tag, k), 32'(dut.u_rf.regs[k]), 32'(mreg[k]));
  endtask

  task automatic model_reset();
    mpc = 32'd0;
    for (int k = 0; k < 8; k++) mreg[k] = 8'd0;
  endtask

  // Architectural behaviour of one instruction at mpc.
  task automatic model_step();
    logic [31:0] i;
    logic [7:0]  a, b;
    int          o;
    logic [31:0] npc;
    i   = imem[mpc[7:2]];
    a   = mreg[i[10:8]];
    b   = mreg[i[2:0]];
    o   = int'($signed(i[23:16]));
    npc = mpc + 32'd4;
    case (i[31:24])
      8'h00: mreg[i[18:16]] = a + b;
      8'h01: mreg[i[18:16]] = a - b;
      8'h02: mreg[i[18:16]] = a & b;
      8'h03: mreg[i[18:16]] = a | b;
      8'h04: npc = mpc + 32'd4 + 32'(o * 4);
      8'h05: if (a == b) npc = mpc + 32'd4 + 32'(o * 4);
      8'h06: mreg[i[18:16]] = b;
      8'h07: mreg[i[18:16]] = i[7:0];
      default: ;
    endcase
    mpc = npc;
  endtask

  task automatic run_cycle(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges and held across one rising edge.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk({tag, "_async_pc"}, PC, 32'd0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_async_r%0d", tag, k), 32'(dut.u_rf.regs[k]), 32'd0);
    @(posedge CLK);
    #1;
    chk({tag, "_held_pc"}, PC, 32'd0);
    chk({tag, "_held_r"}, 32'(dut.u_rf.regs), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
  endtask

  initial begin
    int cycles, taken, ntaken;
    logic [31:0] prev;

    vt[0]  = '{enc(7, 4, 0, 8'h0A), 4, 8'h0A};
    vt[1]  = '{enc(7, 2, 0, 8'hF0), 2, 8'hF0};
    vt[2]  = '{enc(7, 3, 0, 8'h3C), 3, 8'h3C};
    vt[3]  = '{enc(2, 1, 2, 3),     1, 8'h30};
    vt[4]  = '{enc(3, 1, 2, 3),     1, 8'hFC};
    vt[5]  = '{enc(0, 1, 2, 3),     1, 8'h2C};
    vt[6]  = '{enc(6, 1, 0, 3),     1, 8'h3C};
    vt[7]  = '{enc(7, 5, 0, 8'h00), 5, 8'h00};
    vt[8]  = '{enc(7, 6, 0, 8'h01), 6, 8'h01};
    vt[9]  = '{enc(1, 7, 5, 6),     7, 8'hFF};
    vt[10] = '{enc(9, 7, 5, 5),     7, 8'hFF};
    vt[11] = '{enc(1, 0, 2, 3),     0, 8'hB4};
    vt[12] = '{enc(0, 0, 3, 3),     0, 8'h78};

    for (int k = 0; k < 64; k++) imem[k] = NOP;
    for (int k = 0; k < 13; k++) imem[k] = vt[k].instr;

    // Power-on reset held for 5 units.
    model_reset();
    #5;
    chk("por_pc", PC, 32'd0);
    chk("por_regs", 32'(dut.u_rf.regs), 32'd0);
    chk("first_fetch", INSTRUCTION, vt[0].instr);
    RESET = 1'b1;

    for (int n = 0; n < 13; n++) begin
      model_step();
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_rd", n), 32'(dut.u_rf.regs[vt[n].rd]), 32'(vt[n].val));
      chk($sformatf("vec%0d_pc", n), PC, 32'(4 * (n + 1)));
      check_all($sformatf("vec%0d", n));
    end

    // Countdown loop; reset lands mid-cycle with live register state.
    for (int k = 0; k < 64; k++) imem[k] = NOP;
    imem[0] = enc(7, 4, 0, 10);
    imem[1] = enc(7, 5, 0, 1);
    imem[2] = enc(7, 6, 0, 1);
    imem[3] = enc(7, 7, 0, 9);
    imem[4] = enc(1, 4, 4, 5);
    imem[5] = enc(5, 1, 4, 6);
    imem[6] = enc(4, 8'hFD, 0, 0);
    imem[7] = enc(0, 1, 4, 7);
    do_reset("rst_loop");
    cycles = 0; taken = 0; ntaken = 0;
    while (PC != 32'd32 && cycles < 40) begin
      prev = PC;
      run_cycle("loop");
      cycles++;
      if (prev == 32'd20 && PC == 32'd28) taken++;
      if (prev == 32'd20 && PC == 32'd24) ntaken++;
    end
    chk("loop_cycles", 32'(cycles), 32'd31);
    chk("loop_r1", 32'(dut.u_rf.regs[1]), 32'd10);
    chk("loop_r4", 32'(dut.u_rf.regs[4]), 32'd1);
    chk("loop_beq_taken", 32'(taken), 32'd1);
    chk("loop_beq_not_taken", 32'(ntaken), 32'd8);

    // Backward jump over unknown opcodes.
    for (int k = 0; k < 64; k++) imem[k] = NOP;
    imem[6] = enc(4, 8'hFD, 0, 0);
    do_reset("rst_jneg");
    for (int n = 0; n < 6; n++) run_cycle("nop");
    chk("nop_pc24", PC, 32'd24);
    run_cycle("jneg");
    chk("j_neg_target", PC, 32'd16);

    // Most negative offset wraps below address 0.
    imem[0] = enc(4, 8'h80, 0, 0);
    do_reset("rst_jwrap");
    run_cycle("jwrap");
    chk("j_wrap_target", PC, 32'hFFFF_FE04);

    // Random programs against the reference model.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 64; k++) begin
        int sel;
        int op;
        sel = int'($urandom_range(0, 10));
        op  = (sel < 8) ? sel : (sel == 8 ? 8'h07 : (sel == 9 ? 8'h09 : 8'hC3));
        imem[k] = enc(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)));
      end
      do_reset("rst_rand");
      for (int n = 0; n < 150; n++) run_cycle($sformatf("rand%0d_%0d", p, n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
